// File: rtl/rv64_fetch_pkg.sv
// Shared fetch-path types and constants used by the instruction ROM and its response queue.
package rv64_fetch_pkg;
    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   addr;
        logic              err;
    } fetch_resp_t;
endpackage

// File: rtl/inst_rom_pipe_if.sv
// Request/response handshake between the PC generator (master) and the instruction ROM (slave).
interface inst_rom_pipe_if import rv64_fetch_pkg::*; ();
    logic              req_valid_i;
    logic              req_ready_o;
    logic [XLEN-1:0]   req_addr_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [INST_W-1:0] resp_inst_o;
    logic [XLEN-1:0]   resp_addr_o;
    logic              resp_err_o;

    modport master (
        output req_valid_i, req_addr_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_inst_o, resp_addr_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_inst_o, resp_addr_o, resp_err_o
    );
endinterface

// File: rtl/fetch_resp_fifo.sv
// First-word-fall-through response queue; pointers carry one extra wrap bit to tell full from empty.
module fetch_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [1 << AW];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/inst_rom_pipe.sv
// Instruction ROM with programmable read latency, credit-limited requests and an ordered response queue.
module inst_rom_pipe import rv64_fetch_pkg::*; #(
    parameter int               DEPTH      = 4096,
    parameter logic [XLEN-1:0]  BASE_ADDR  = 64'h8000_0000,
    parameter int               LATENCY    = 1,
    parameter int               RESP_DEPTH = 4,
    parameter string            INIT_FILE  = ""
) (
    input logic            clk,
    input logic            rst,
    input logic            flush_i,
    inst_rom_pipe_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int STAGES = LATENCY - 1;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("inst_rom_pipe: LATENCY %0d outside legal range 1..4", LATENCY);
    end

    logic [INST_W-1:0] rom [DEPTH];

    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             pop;
    logic             push_vld;
    logic [XLEN-1:0]  push_addr;
    logic [IDX_W-1:0] push_idx;
    logic             push_err;
    fetch_resp_t      push_data;
    fetch_resp_t      head;
    logic             fifo_empty;
    logic             fifo_full;

    // Credits cover both in-flight and queued fetches, so the queue can never overflow.
    assign bus.req_ready_o  = !rst && !flush_i && (cnt < CNT_W'(RESP_DEPTH));
    assign accept           = bus.req_valid_i && bus.req_ready_o;
    assign bus.resp_valid_o = !fifo_empty && !flush_i;
    assign pop              = bus.resp_valid_o && bus.resp_ready_i;

    // ---- delay stages p0..p(STAGES-1) ----
    if (STAGES == 0) begin : g_no_delay
        assign push_vld  = accept;
        assign push_addr = bus.req_addr_i;
    end else begin : g_delay
        logic            vld_p  [STAGES];
        logic [XLEN-1:0] addr_p [STAGES];

        always_ff @(posedge clk or posedge rst) begin
            if (rst || flush_i) begin
                for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
            end else begin
                vld_p[0] <= accept;
                for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
            end
        end

        always_ff @(posedge clk) begin
            addr_p[0] <= bus.req_addr_i;
            for (int i = 1; i < STAGES; i++) addr_p[i] <= addr_p[i-1];
        end

        assign push_vld  = vld_p[STAGES-1];
        assign push_addr = addr_p[STAGES-1];
    end

    // ---- final stage: ROM read and queue push on the same edge ----
    assign push_idx = push_addr[IDX_W+1:2];
    assign push_err = (push_addr[1:0] != 2'b00) ||
                      (push_addr[XLEN-1:IDX_W+2] != BASE_ADDR[XLEN-1:IDX_W+2]);

    always_comb begin
        push_data      = '0;
        push_data.inst = push_err ? NOP_INST : rom[push_idx];
        push_data.addr = push_addr;
        push_data.err  = push_err;
    end

    fetch_resp_fifo #(
        .WIDTH ($bits(fetch_resp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .push      (push_vld && !flush_i),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_vld && !flush_i && fifo_full));

    assign bus.resp_inst_o = fifo_empty ? '0 : head.inst;
    assign bus.resp_addr_o = fifo_empty ? '0 : head.addr;
    assign bus.resp_err_o  = fifo_empty ? 1'b0 : head.err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (flush_i)
            cnt <= '0;
        else if (accept && !pop)
            cnt <= cnt + 1'b1;
        else if (pop && !accept)
            cnt <= cnt - 1'b1;
    end
endmodule
